// File: rtl/field_packer_if.sv
// Field-in / word-out bus of field_packer: valid-ready fields in, valid-ready packed words out.
// Master drives fields and out_ready (producer/consumer side); slave is the packer.
interface field_packer_if #(
    parameter int WORD_W = 32,
    parameter int MAXF   = 16
);
    localparam int LW = $clog2(MAXF + 1);
    localparam int BW = $clog2(WORD_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [MAXF-1:0]   in_data;
    logic [LW-1:0]     in_len;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [BW-1:0]     out_bits;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_len, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_bits, out_last
    );

    modport slave (
        input  in_valid, in_data, in_len, in_last, out_ready,
        output in_ready, out_valid, out_data, out_bits, out_last
    );
endinterface

// File: rtl/field_packer.sv
// Packs variable-length fields into WORD_W-bit words; words appear one cycle after the accepting edge.
// in_ready drops while fewer than two FIFO slots are free; FIELD_PACKER_MSB_FIRST_EN selects MSB-first packing.
module field_packer #(
    parameter int WORD_W = 32,
    parameter int MAXF   = 16,
    parameter int DEPTH  = 4
) (
    input logic          clk,
    input logic          rst_n,
    field_packer_if.slave bus
);
    localparam int LW = $clog2(MAXF + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam int W2 = WORD_W + MAXF;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              last;
        logic [BW-1:0]     bits;
        logic [WORD_W-1:0] data;
    } word_t;

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [BW-1:0]     ptr_q, ptr_d;
    logic              dirty_q, dirty_d;
    word_t             mem_q [DEPTH];
    word_t             mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;

    logic              fire, pop, split, flush_vld;
    logic [LW-1:0]     len_eff;
    logic [MAXF-1:0]   fld;
    logic [W2-1:0]     comb;
    logic [WORD_W-1:0] lo_word, hi_word;
    int                sum, ptr_after, n_push;
    word_t             ent0, ent1, flush_ent;

    assign bus.in_ready  = (count_q <= CW'(DEPTH - 2));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_q].data;
    assign bus.out_bits  = mem_q[rd_q].bits;
    assign bus.out_last  = mem_q[rd_q].last;
    assign fire = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin : pack
        len_eff = (bus.in_len > LW'(MAXF)) ? LW'(MAXF) : bus.in_len;
        for (int i = 0; i < MAXF; i++) begin
            fld[i] = bus.in_data[i] && (i < int'(len_eff));
        end
        sum   = int'(ptr_q) + int'(len_eff);
        split = (sum >= WORD_W);
        // acc sits in a WORD_W+MAXF window so a crossing field lands whole, then splits at the word seam
`ifdef FIELD_PACKER_MSB_FIRST_EN
        comb    = {acc_q, {MAXF{1'b0}}} | ({{WORD_W{1'b0}}, fld} << (W2 - sum));
        lo_word = comb[W2-1 -: WORD_W];
        hi_word = WORD_W'(comb[MAXF-1:0]) << (WORD_W - MAXF);
`else
        comb    = {{MAXF{1'b0}}, acc_q} | ({{WORD_W{1'b0}}, fld} << ptr_q);
        lo_word = comb[WORD_W-1:0];
        hi_word = WORD_W'(comb[W2-1:WORD_W]);
`endif
        ptr_after = split ? sum - WORD_W : sum;

        acc_d     = acc_q;
        ptr_d     = ptr_q;
        dirty_d   = dirty_q;
        flush_vld = 1'b0;
        flush_ent = '0;
        ent0      = '0;
        ent1      = '0;
        n_push    = 0;
        if (fire) begin
            acc_d   = split ? hi_word : lo_word;
            ptr_d   = BW'(ptr_after);
            dirty_d = dirty_q || split;
            if (bus.in_last) begin
                // empty marker only when the group produced no word at all
                flush_vld = (ptr_after > 0) || (!dirty_q && !split);
                flush_ent = '{last: 1'b1, bits: BW'(ptr_after), data: acc_d};
                acc_d     = '0;
                ptr_d     = '0;
                dirty_d   = 1'b0;
            end
            ent0   = split ? '{last: bus.in_last && (sum == WORD_W), bits: BW'(WORD_W), data: lo_word}
                           : flush_ent;
            ent1   = flush_ent;
            n_push = int'(split) + int'(flush_vld);
        end
    end

    always_comb begin : fifo
        mem_d = mem_q;
        if (n_push > 0) mem_d[wr_q] = ent0;
        if (n_push > 1) mem_d[wr_q + AW'(1)] = ent1;
        wr_d    = wr_q + AW'(n_push);
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = CW'(int'(count_q) + n_push - int'(pop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            ptr_q   <= '0;
            dirty_q <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            dirty_q <= dirty_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_field_packer.sv
// Directed and random checks of field_packer against a bit-queue reference model.
module tb_field_packer;
    localparam int WORD_W = 32;
    localparam int MAXF   = 16;
    localparam int DEPTH  = 4;
    localparam int LW     = 5;
    localparam int BW     = 6;
    localparam int BOUND  = 64;
`ifdef FIELD_PACKER_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [BW-1:0]     bits;
        logic              last;
    } word_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    rand_rdy = 1'b0;
    word_t exp_q[$];
    word_t got_q[$];
    bit    cur_q[$];
    bit    grp = 1'b0;
    bit    hold_vld = 1'b0;
    word_t hold_w;

    field_packer_if #(.WORD_W(WORD_W), .MAXF(MAXF)) bus ();
    field_packer #(.WORD_W(WORD_W), .MAXF(MAXF), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: fields become a stream of bits; every WORD_W bits (or a flush) make a word.
    function automatic void emit(bit last);
        word_t w;
        w = '0;
        for (int i = 0; i < cur_q.size(); i++) begin
            if (MSB) w.data[WORD_W-1-i] = cur_q[i];
            else     w.data[i] = cur_q[i];
        end
        w.bits = BW'(cur_q.size());
        w.last = last;
        exp_q.push_back(w);
        cur_q.delete();
        grp = 1'b1;
    endfunction

    function automatic void model_field(logic [MAXF-1:0] d, int len, bit last);
        int l;
        l = (len > MAXF) ? MAXF : len;
        for (int i = 0; i < l; i++) begin
            cur_q.push_back(MSB ? d[l-1-i] : d[i]);
            if (cur_q.size() == WORD_W) emit(last && (i == l - 1));
        end
        if (last) begin
            if (cur_q.size() > 0 || !grp) emit(1'b1);
            grp = 1'b0;
        end
    endfunction

    function automatic word_t head();
        return '{bus.out_data, bus.out_bits, bus.out_last};
    endfunction

    task automatic monitor();
        word_t w, e;
        if (!rst_n) begin
            hold_vld = 1'b0;
            return;
        end
        w = head();
        if (hold_vld) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_stable", 64'(w), 64'(hold_w));
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("word_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("word", 64'(w), 64'(e));
            end
            got_q.push_back(w);
        end
        hold_vld = bus.out_valid && !bus.out_ready;
        hold_w   = w;
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        step_edge();
    endtask

    task automatic send(input logic [MAXF-1:0] d, input int len, input bit last);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_len   = LW'(len);
        bus.in_last  = last;
        for (int w = 0; w < BOUND && !ok; w++) begin
            @(negedge clk);
            monitor();
            if (bus.in_ready) begin
                ok = 1'b1;
                model_field(d, len, last);
            end
            step_edge();
        end
        if (!ok) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < BOUND && (exp_q.size() > 0 || bus.out_valid); i++) cyc();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_idle", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic chk_got(input string tag, input int idx, input logic [WORD_W-1:0] data,
                           input int bits, input bit last);
        if (got_q.size() > idx) chk(tag, 64'(got_q[idx]), 64'(word_t'{data, BW'(bits), last}));
        else chk({tag, "_present"}, 64'(got_q.size()), 64'(idx + 1));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_len = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_word", 64'(head()), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;

        // four bytes -> one full word
        got_q.delete();
        send(16'h11, 8, 1'b0);
        send(16'h22, 8, 1'b0);
        send(16'h33, 8, 1'b0);
        chk("bytes_no_early_word", 64'(bus.out_valid), 64'd0);
        send(16'h44, 8, 1'b0);
        chk("bytes_latency", 64'(bus.out_valid), 64'd1);
        repeat (3) cyc();
        chk_got("bytes_word", 0, MSB ? 32'h11223344 : 32'h44332211, 32, 1'b0);

        // split across a word boundary, then flush
        got_q.delete();
        send(16'hABC, 12, 1'b0);
        send(16'hDEF, 12, 1'b0);
        send(16'h123, 12, 1'b1);
        repeat (4) cyc();
        chk_got("split_w0", 0, MSB ? 32'hABCDEF12 : 32'h23DEFABC, 32, 1'b0);
        chk_got("split_w1", 1, MSB ? 32'h30000000 : 32'h00000001, 4, 1'b1);

        // masking of high bits and clamping of in_len
        got_q.delete();
        send(16'hFFFF, 4, 1'b0);
        send(16'hFFFF, 20, 1'b1);
        repeat (3) cyc();
        chk_got("clamp_word", 0, MSB ? 32'hFFFFF000 : 32'h000FFFFF, 20, 1'b1);

        // empty flush, then exact fill with last
        got_q.delete();
        send(16'h0, 0, 1'b1);
        repeat (3) cyc();
        chk_got("empty_flush", 0, 32'h0, 0, 1'b1);
        got_q.delete();
        send(16'h01, 8, 1'b0);
        send(16'h02, 8, 1'b0);
        send(16'h03, 8, 1'b0);
        send(16'h04, 8, 1'b1);
        repeat (4) cyc();
        chk("exact_fill_count", 64'(got_q.size()), 64'd1);
        chk_got("exact_fill_word", 0, MSB ? 32'h01020304 : 32'h04030201, 32, 1'b1);

        // backpressure: FIFO fills to DEPTH-1, producer held, then drains in order
        got_q.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(16'(i), 8, 1'b0);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd12;
        bus.in_len   = LW'(8);
        bus.in_last  = 1'b0;
        repeat (3) begin
            cyc();
            chk("bp_held", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        for (int i = 12; i < 16; i++) send(16'(i), 8, 1'b0);
        drain();
        chk("bp_word_count", 64'(got_q.size()), 64'd4);
        chk_got("bp_w0", 0, MSB ? 32'h00010203 : 32'h03020100, 32, 1'b0);
        chk_got("bp_w3", 3, MSB ? 32'h0C0D0E0F : 32'h0F0E0D0C, 32, 1'b0);

        // push and pop on the same edge at count 2
        bus.out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(16'(8'h20 + i), 8, 1'b0);
        bus.out_ready = 1'b1;
        send(16'h2B, 8, 1'b0);
        bus.out_ready = 1'b0;
        chk("pushpop_count2", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) send(16'(8'h30 + i), 8, 1'b0);
        chk("pushpop_count3", 64'(bus.in_ready), 64'd0);
        drain();

        // reset with a partial word and queued words
        bus.out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send(16'(8'h50 + i), 8, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        cur_q.delete();
        got_q.delete();
        grp = 1'b0;
        hold_vld = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        bus.out_ready = 1'b1;
        send(16'hA1, 8, 1'b0);
        send(16'hA2, 8, 1'b0);
        send(16'hA3, 8, 1'b0);
        send(16'hA4, 8, 1'b0);
        repeat (3) cyc();
        chk("midrst_count", 64'(got_q.size()), 64'd1);
        chk_got("midrst_word", 0, MSB ? 32'hA1A2A3A4 : 32'hA4A3A2A1, 32, 1'b0);

        // random fields, lengths, flushes and consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++)
            send(16'($urandom), int'($urandom_range(0, 31)), $urandom_range(0, 7) == 0);
        send(16'h0, 0, 1'b1);
        rand_rdy = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
